// File: rtl/zsram_read_sequencer_if.sv
// Request, cell-array and response signals of the ZSRAM read sequencer.
// CellParity/RespParityErr exist only when ZSRAM_READ_PARITY_EN is defined.
interface zsram_read_sequencer_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                       ReqValid;
    logic                       ReqReady;
    logic [ADDR_WIDTH-1:0]      ReqAddr;
    logic [2**ADDR_WIDTH-1:0]   RowSelect;
    logic                       ReadEdge;
    logic [DATA_WIDTH-1:0]      CellData;
    logic                       RespValid;
    logic                       RespReady;
    logic [DATA_WIDTH-1:0]      RespData;
    logic                       Busy;
`ifdef ZSRAM_READ_PARITY_EN
    logic                       CellParity;
    logic                       RespParityErr;

    modport master (
        output ReqValid, ReqAddr, CellData, CellParity, RespReady,
        input  ReqReady, RowSelect, ReadEdge, RespValid, RespData,
        input  RespParityErr, Busy
    );

    modport slave (
        input  ReqValid, ReqAddr, CellData, CellParity, RespReady,
        output ReqReady, RowSelect, ReadEdge, RespValid, RespData,
        output RespParityErr, Busy
    );
`else
    modport master (
        output ReqValid, ReqAddr, CellData, RespReady,
        input  ReqReady, RowSelect, ReadEdge, RespValid, RespData, Busy
    );

    modport slave (
        input  ReqValid, ReqAddr, CellData, RespReady,
        output ReqReady, RowSelect, ReadEdge, RespValid, RespData, Busy
    );
`endif
endinterface

// File: rtl/zsram_read_sequencer.sv
// Read-side sequencer for the Zero Second RAM array: select, strobe, settle, sample, respond.
// Optional parity check on the sampled word is enabled with ZSRAM_READ_PARITY_EN.
module zsram_read_sequencer #(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int EDGE_CYCLES   = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                   Crystal50Mhz1,
    input  logic                   Reset,
    zsram_read_sequencer_if.slave  bus
);
    localparam int ROWS = 2**ADDR_WIDTH;
    localparam int CMAX = (EDGE_CYCLES > SETTLE_CYCLES) ? EDGE_CYCLES : SETTLE_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] EDGE_LD   = CW'(EDGE_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [ROWS-1:0] ROW_ONE = {{(ROWS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EDGE,
        S_SETTLE,
        S_SAMPLE,
        S_RESPOND
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_next;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [ADDR_WIDTH-1:0]  w_addr_next;
    logic [ROWS-1:0]        w_row_next;

    logic                   r_req_ready;
    logic [ROWS-1:0]        r_row_sel;
    logic                   r_read_edge;
    logic                   r_resp_valid;
    logic [DATA_WIDTH-1:0]  r_resp_data;
    logic                   r_busy;

    // Next-state, phase counter and address latch selection
    always_comb begin
        w_next      = r_state;
        w_cnt_next  = r_cnt;
        w_addr_next = r_addr;
        unique case (r_state)
            S_IDLE: begin
                if (bus.ReqValid && r_req_ready) begin
                    w_addr_next = bus.ReqAddr;
                    w_next      = S_SELECT;
                end
            end
            S_SELECT: begin
                w_cnt_next = EDGE_LD;
                w_next     = S_EDGE;
            end
            S_EDGE: begin
                if (r_cnt == '0) begin
                    if (SETTLE_CYCLES == 0) begin
                        w_next = S_SAMPLE;
                    end else begin
                        w_cnt_next = SETTLE_LD;
                        w_next     = S_SETTLE;
                    end
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_SETTLE: begin
                if (r_cnt == '0) begin
                    w_next = S_SAMPLE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_SAMPLE: begin
                w_next = S_RESPOND;
            end
            S_RESPOND: begin
                if (bus.RespReady) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Row select decoded from the next state so the registered output never glitches
    always_comb begin
        w_row_next = '0;
        if (w_next == S_SELECT || w_next == S_EDGE || w_next == S_SETTLE) begin
            w_row_next = ROW_ONE << w_addr_next;
        end
    end

    // State, counter and latched address
    always_ff @(posedge Crystal50Mhz1 or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_addr  <= w_addr_next;
        end
    end

    // Registered outputs, aligned with the state they belong to
    always_ff @(posedge Crystal50Mhz1 or posedge Reset) begin
        if (Reset) begin
            r_req_ready  <= 1'b0;
            r_row_sel    <= '0;
            r_read_edge  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_req_ready  <= (w_next == S_IDLE);
            r_row_sel    <= w_row_next;
            r_read_edge  <= (w_next == S_EDGE);
            r_resp_valid <= (w_next == S_RESPOND);
            r_busy       <= (w_next != S_IDLE);
        end
    end

    // Capture the cell bus once the settle window has elapsed
    always_ff @(posedge Crystal50Mhz1 or posedge Reset) begin
        if (Reset) begin
            r_resp_data <= '0;
        end else if (r_state == S_SAMPLE) begin
            r_resp_data <= bus.CellData;
        end
    end

`ifdef ZSRAM_READ_PARITY_EN
    logic r_parity_err;

    // Even parity over data plus parity bit, captured with the data
    always_ff @(posedge Crystal50Mhz1 or posedge Reset) begin
        if (Reset) begin
            r_parity_err <= 1'b0;
        end else if (r_state == S_SAMPLE) begin
            r_parity_err <= (^bus.CellData) ^ bus.CellParity;
        end
    end

    assign bus.RespParityErr = r_parity_err;
`endif

    assign bus.ReqReady  = r_req_ready;
    assign bus.RowSelect = r_row_sel;
    assign bus.ReadEdge  = r_read_edge;
    assign bus.RespValid = r_resp_valid;
    assign bus.RespData  = r_resp_data;
    assign bus.Busy      = r_busy;

endmodule

// File: tb/tb_zsram_read_sequencer.sv
// Bench for zsram_read_sequencer: two instances (default timing, and 1-edge/0-settle)
// share stimulus; each is checked against a phase-count reference model.
module tb_zsram_read_sequencer;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int EA = 2;
    localparam int SA = 1;
    localparam int EB = 1;
    localparam int SB = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          rv = 1'b0;
    logic [AW-1:0] ra = '0;
    logic          rr = 1'b0;
    logic [DW-1:0] cd = '0;
    logic          cp = 1'b0;

    int vec = 0;
    int err = 0;

    zsram_read_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifa ();
    zsram_read_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifb ();

    assign ifa.ReqValid  = rv;
    assign ifa.ReqAddr   = ra;
    assign ifa.RespReady = rr;
    assign ifa.CellData  = cd;
    assign ifb.ReqValid  = rv;
    assign ifb.ReqAddr   = ra;
    assign ifb.RespReady = rr;
    assign ifb.CellData  = cd;
`ifdef ZSRAM_READ_PARITY_EN
    assign ifa.CellParity = cp;
    assign ifb.CellParity = cp;
`endif

    zsram_read_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .EDGE_CYCLES(EA), .SETTLE_CYCLES(SA)
    ) dut_a (
        .Crystal50Mhz1(clk),
        .Reset(rst),
        .bus(ifa.slave)
    );

    zsram_read_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .EDGE_CYCLES(EB), .SETTLE_CYCLES(SB)
    ) dut_b (
        .Crystal50Mhz1(clk),
        .Reset(rst),
        .bus(ifb.slave)
    );

    // Reference model: phase = clocks since the accepting cycle (0 = idle)
    int            ph     [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_data [2];
    bit            m_rdy  [2];
    bit            m_perr [2];

    function automatic int e_of(int d);
        return (d == 0) ? EA : EB;
    endfunction

    function automatic int s_of(int d);
        return (d == 0) ? SA : SB;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ph[d]     = 0;
            m_addr[d] = '0;
            m_data[d] = '0;
            m_rdy[d]  = 1'b0;
            m_perr[d] = 1'b0;
        end
    endtask

    task automatic model_step(int d);
        int e = e_of(d);
        int s = s_of(d);
        if (ph[d] == 0) begin
            if (rv && m_rdy[d]) begin
                ph[d]     = 1;
                m_addr[d] = ra;
            end
        end else if (ph[d] >= 3 + e + s) begin
            if (rr) ph[d] = 0;
        end else begin
            if (ph[d] == 2 + e + s) begin
                m_data[d] = cd;
                m_perr[d] = (^cd) ^ cp;
            end
            ph[d]++;
        end
        m_rdy[d] = 1'b1;
    endtask

    task automatic check_dut(int d, logic rdy, logic [15:0] rs, logic re,
                             logic vld, logic [DW-1:0] dat, logic bsy, logic pe);
        int            p   = ph[d];
        int            e   = e_of(d);
        int            s   = s_of(d);
        string         n   = (d == 0) ? "A" : "B";
        logic [15:0]   one = 16'h0001;
        logic [15:0]   ers;
        ers = (p >= 1 && p <= 1 + e + s) ? (one << m_addr[d]) : 16'h0000;
        chk($sformatf("%s_ReqReady", n), 32'(rdy), 32'(p == 0 && m_rdy[d]));
        chk($sformatf("%s_RowSelect", n), 32'(rs), 32'(ers));
        chk($sformatf("%s_ReadEdge", n), 32'(re), 32'(p >= 2 && p <= 1 + e));
        chk($sformatf("%s_RespValid", n), 32'(vld), 32'(p >= 3 + e + s));
        chk($sformatf("%s_Busy", n), 32'(bsy), 32'(p != 0));
        if (p >= 3 + e + s) begin
            chk($sformatf("%s_RespData", n), 32'(dat), 32'(m_data[d]));
`ifdef ZSRAM_READ_PARITY_EN
            chk($sformatf("%s_RespParityErr", n), 32'(pe), 32'(m_perr[d]));
`endif
        end
        if (pe === 1'bz) vec = vec;
    endtask

    task automatic check_all();
        logic pa = 1'b0;
        logic pb = 1'b0;
`ifdef ZSRAM_READ_PARITY_EN
        pa = ifa.RespParityErr;
        pb = ifb.RespParityErr;
`endif
        check_dut(0, ifa.ReqReady, ifa.RowSelect, ifa.ReadEdge,
                  ifa.RespValid, ifa.RespData, ifa.Busy, pa);
        check_dut(1, ifb.ReqReady, ifb.RowSelect, ifb.ReadEdge,
                  ifb.RespValid, ifb.RespData, ifb.Busy, pb);
    endtask

    // One clock: drive inputs, advance model, check after the edge
    task automatic cyc(logic v, logic [AW-1:0] a, logic r, logic [DW-1:0] c, logic par);
        rv = v;
        ra = a;
        rr = r;
        cd = c;
        cp = par;
        model_step(0);
        model_step(1);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("A_RespData_rst", 32'(ifa.RespData), 32'h0);
        chk("B_RespData_rst", 32'(ifb.RespData), 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((ph[0] != 0 || ph[1] != 0) && k < 50) begin
            cyc(1'b0, '0, 1'b1, 8'($urandom), 1'b0);
            k++;
        end
        cyc(1'b0, '0, 1'b1, 8'($urandom), 1'b0);
        chk("drain_busy", 32'({ifa.Busy, ifb.Busy}), 32'h0);
    endtask

    initial begin
        int n;
        int idx;
        int cnt;
        int t_acc [3];
        bit acc;

        model_reset();
        apply_reset();
        cyc(1'b0, '0, 1'b1, 8'h00, 1'b0);

        // Single read of row 3, latency measured on the default instance
        cyc(1'b1, 4'h3, 1'b1, 8'hA5, 1'b0);
        n = 1;
        while (!ifa.RespValid && n < 20) begin
            cyc(1'b0, 4'hC, 1'b1, 8'hA5, 1'b0);
            n++;
        end
        chk("lat_A", 32'(n), 32'd6);
        chk("data_A5", 32'(ifa.RespData), 32'hA5);
        drain();

        // Row F with the consumer stalling; requests during the stall are ignored
        cyc(1'b1, 4'hF, 1'b0, 8'($urandom), 1'b0);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 4'($urandom), 1'b0, 8'($urandom), 1'b0);
        end
        chk("stall_valid", 32'(ifa.RespValid), 32'h1);
        cyc(1'b0, '0, 1'b1, 8'($urandom), 1'b0);
        chk("release_valid", 32'(ifa.RespValid), 32'h0);
        chk("release_ready", 32'(ifa.ReqReady), 32'h1);
        drain();

        // Continuous requests to rows 0,1,2 on the default instance
        idx = 0;
        cnt = 0;
        while (idx < 3 && cnt < 60) begin
            acc = (ph[0] == 0) && m_rdy[0];
            cyc(1'b1, 4'(idx), 1'b1, 8'($urandom), 1'b0);
            if (acc) begin
                t_acc[idx] = cnt;
                idx++;
            end
            cnt++;
        end
        chk("b2b_count", 32'(idx), 32'd3);
        chk("b2b_period1", 32'(t_acc[1] - t_acc[0]), 32'd7);
        chk("b2b_period2", 32'(t_acc[2] - t_acc[1]), 32'd7);
        drain();

        // Reset during the strobe of a row-5 read
        cyc(1'b1, 4'h5, 1'b1, 8'($urandom), 1'b0);
        n = 0;
        while (ph[0] != 2 && n < 10) begin
            cyc(1'b0, 4'h0, 1'b1, 8'($urandom), 1'b0);
            n++;
        end
        chk("pre_rst_edge", 32'(ifa.ReadEdge), 32'h1);
        @(posedge clk);
        #2;
        apply_reset();
        cyc(1'b0, '0, 1'b1, 8'($urandom), 1'b0);
        chk("post_rst_ready", 32'(ifa.ReqReady), 32'h1);
        drain();

        // Short-timing instance: data changes in the final strobe cycle
        cyc(1'b1, 4'h9, 1'b1, 8'h11, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 8'h11, 1'b0);
        n = 2;
        while (!ifb.RespValid && n < 20) begin
            cyc(1'b0, 4'h0, 1'b1, 8'h3C, 1'b0);
            n++;
        end
        chk("lat_B", 32'(n), 32'd4);
        chk("data_3C", 32'(ifb.RespData), 32'h3C);
        drain();

`ifdef ZSRAM_READ_PARITY_EN
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 4'h2, 1'b1, 8'h07, 1'(1 - k));
            n = 1;
            while (!ifa.RespValid && n < 20) begin
                cyc(1'b0, 4'h0, 1'b1, 8'h07, 1'(1 - k));
                n++;
            end
            chk("parity_dir", 32'(ifa.RespParityErr), 32'(k));
            drain();
        end
`endif

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0),
                8'($urandom), 1'($urandom));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
